// File: rtl/dm_access_ctrl.sv
// Memory-stage data-memory sequencer: issues one DM request per load/store,
// stalls the pipeline until completion, and returns extended load data.
module dm_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_re,
  input  logic        m_we,
  input  logic [1:0]  m_size,
  input  logic        m_unsigned,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [3:0] byteen_f(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b10:   byteen_f = 4'b0001 << off;
      2'b01:   byteen_f = off[1] ? 4'b1100 : 4'b0011;
      default: byteen_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_f(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b10:   wdata_f = {4{w[7:0]}};
      2'b01:   wdata_f = {2{w[15:0]}};
      default: wdata_f = w;
    endcase
  endfunction

  function automatic logic [31:0] extend_f(input logic [1:0] size, input logic uns,
                                           input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b10:   extend_f = {{24{b[7] & ~uns}}, b};
      2'b01:   extend_f = {{16{h[15] & ~uns}}, h};
      default: extend_f = rdata;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        drop_q, drop_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [3:0]  byteen_q, byteen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        ld_valid_q, ld_valid_d;
  logic        exc_bus_q, exc_bus_d;

  logic new_s, mis_s, hit_timeout_s;

  // Issue qualification and misalignment detection for the M-stage access.
  always_comb begin
    new_s = reset & (state_q == S_IDLE) & m_valid & (m_re | m_we) & ~flush;
    case (m_size)
      2'b01:   mis_s = m_addr[0];
      2'b10:   mis_s = 1'b0;
      default: mis_s = (m_addr[1:0] != 2'b00);
    endcase
    hit_timeout_s = (cnt_q == 8'(TIMEOUT - 1));
  end

  assign exc_adel = new_s & mis_s & m_re;
  assign exc_ades = new_s & mis_s & m_we;
  assign stall    = (new_s & ~mis_s) | (state_q == S_WAIT);

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    byteen_d   = byteen_q;
    wdata_d    = wdata_q;
    ld_data_d  = ld_data_q;
    ld_valid_d = 1'b0;
    exc_bus_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (new_s && !mis_s) begin
          state_d  = S_WAIT;
          cnt_d    = 8'd0;
          drop_d   = 1'b0;
          req_d    = 1'b1;
          we_d     = m_we;
          addr_d   = {m_addr[31:2], 2'b00};
          off_d    = m_addr[1:0];
          size_d   = m_size;
          uns_d    = m_unsigned;
          byteen_d = byteen_f(m_size, m_addr[1:0]);
          wdata_d  = wdata_f(m_size, m_wdata);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d  = cnt_q + 8'd1;
        drop_d = drop_q | flush;
        // A ready arriving on the final counted cycle still wins over the timeout.
        if (mem_ready) begin
          state_d    = S_DONE;
          req_d      = 1'b0;
          we_d       = 1'b0;
          ld_data_d  = extend_f(size_q, uns_q, off_q, mem_rdata);
          ld_valid_d = ~we_q & ~drop_q & ~flush;
        end else if (hit_timeout_s) begin
          state_d   = S_DONE;
          req_d     = 1'b0;
          we_d      = 1'b0;
          ld_data_d = 32'd0;
          exc_bus_d = ~drop_q & ~flush;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        drop_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset drops any in-flight request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      byteen_q   <= 4'd0;
      wdata_q    <= 32'd0;
      ld_data_q  <= 32'd0;
      ld_valid_q <= 1'b0;
      exc_bus_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      byteen_q   <= byteen_d;
      wdata_q    <= wdata_d;
      ld_data_q  <= ld_data_d;
      ld_valid_q <= ld_valid_d;
      exc_bus_q  <= exc_bus_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_byteen = byteen_q;
  assign mem_wdata  = wdata_q;
  assign ld_data    = ld_data_q;
  assign ld_valid   = ld_valid_q;
  assign exc_bus    = exc_bus_q;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed vector table, hand sequences for reset and
// flush corners, and random transactions against a byte-lane reference model.
module tb_dm_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid, m_re, m_we, m_unsigned, flush;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_byteen;
  logic        stall, ld_valid, exc_adel, exc_ades, exc_bus;
  logic [31:0] ld_data;

  dm_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .m_valid(m_valid), .m_re(m_re), .m_we(m_we),
    .m_size(m_size), .m_unsigned(m_unsigned), .m_addr(m_addr), .m_wdata(m_wdata),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_byteen(mem_byteen), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .exc_adel(exc_adel), .exc_ades(exc_ades), .exc_bus(exc_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        re, we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr, wdata, rdata;
    int          k, fl;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld;
    logic        e_ldv, e_bus, e_adel, e_ades;
    int          e_req, e_stall;
    logic        chk_ld;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  logic        o_adel, o_ades, o_we, o_ldv_done;
  logic [3:0]  o_be;
  logic [31:0] o_wd, o_addr, o_ld;
  int          o_req, o_stall, o_bus, o_ldv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic re, we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, wdata, rdata, input int k, fl,
                               input logic [3:0] be, input logic [31:0] wd, ld,
                               input logic ldv, bus, adel, ades, input int req, stl,
                               input logic cld);
    vec_t v;
    v.re = re; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.k = k; v.fl = fl; v.e_be = be; v.e_wd = wd; v.e_ld = ld;
    v.e_ldv = ldv; v.e_bus = bus; v.e_adel = adel; v.e_ades = ades; v.e_req = req;
    v.e_stall = stl; v.chk_ld = cld;
    return v;
  endfunction

  // Reference: access size in bytes, lane selection and extension by arithmetic.
  function automatic vec_t model(input vec_t v);
    int n, lo, endc;
    bit aligned, ok, fld;
    logic [63:0] val, mask;
    n = (v.size == 2'b01) ? 2 : (v.size == 2'b10) ? 1 : 4;
    lo = int'(v.addr[1:0]);
    aligned = (lo % n) == 0;
    v.e_adel = !aligned && v.re;
    v.e_ades = !aligned && v.we;
    ok   = (v.k >= 1) && (v.k <= TO);
    endc = ok ? v.k : TO;
    fld  = (v.fl >= 1) && (v.fl <= endc);
    v.e_stall = aligned ? endc + 1 : 0;
    v.e_req   = aligned ? endc : 0;
    v.e_ldv   = aligned && v.re && ok && !fld;
    v.e_bus   = aligned && !ok && !fld;
    v.chk_ld  = aligned && v.re && !fld;
    for (int i = 0; i < 4; i++) begin
      v.e_be[i] = (i >= lo) && (i < lo + n);
      v.e_wd[8*i +: 8] = v.wdata[8*(i % n) +: 8];
    end
    mask = (64'd1 << (8 * n)) - 64'd1;
    val  = ({32'd0, v.rdata} >> (8 * lo)) & mask;
    if (!v.uns && n < 4 && val[8*n-1]) val = val | ~mask;
    v.e_ld = ok ? val[31:0] : 32'd0;
    return v;
  endfunction

  task automatic idle_inputs();
    m_valid = 1'b0; m_re = 1'b0; m_we = 1'b0; m_size = 2'b00; m_unsigned = 1'b0;
    m_addr = 32'd0; m_wdata = 32'd0; flush = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
  endtask

  // Entered and left at posedge+1 of an IDLE cycle.
  task automatic run_txn(input vec_t v, input string tag);
    bit done;
    m_valid = 1'b1; m_re = v.re; m_we = v.we; m_size = v.size; m_unsigned = v.uns;
    m_addr = v.addr; m_wdata = v.wdata; mem_rdata = v.rdata; mem_ready = 1'b0; flush = 1'b0;
    o_req = 0; o_stall = 0; o_bus = 0; o_ldv = 0; o_ldv_done = 1'b0;
    o_be = 4'd0; o_wd = 32'd0; o_addr = 32'd0; o_we = 1'b0; o_ld = 32'd0;
    @(negedge clk);
    o_adel = exc_adel; o_ades = exc_ades;
    if (stall) o_stall++;
    if (mem_req) o_req++;
    done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(posedge clk); #1;
      m_valid = 1'b0; m_re = 1'b0; m_we = 1'b0;
      mem_ready = (c == v.k); flush = (c == v.fl);
      @(negedge clk);
      if (mem_req) begin
        if (o_req == 0) begin
          o_be = mem_byteen; o_wd = mem_wdata; o_addr = mem_addr; o_we = mem_we;
        end
        o_req++;
      end
      if (stall) o_stall++;
      else begin
        done = 1'b1; o_ld = ld_data; o_ldv_done = ld_valid;
      end
      if (exc_bus) o_bus++;
      if (ld_valid) o_ldv++;
    end
    if (!done) begin
      n_vec++; n_bad++;
      $display("FAIL %s.hang: stall still high after 40 cycles, required to release", tag);
    end
    @(posedge clk); #1;
    mem_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    if (exc_bus) o_bus++;
    if (ld_valid) o_ldv++;
    @(posedge clk); #1;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, ".adel"}, 32'(o_adel), 32'(v.e_adel));
    chk({tag, ".ades"}, 32'(o_ades), 32'(v.e_ades));
    chk({tag, ".stall_cycles"}, o_stall, v.e_stall);
    chk({tag, ".req_cycles"}, o_req, v.e_req);
    chk({tag, ".ld_valid_pulses"}, o_ldv, 32'(v.e_ldv));
    chk({tag, ".exc_bus_pulses"}, o_bus, 32'(v.e_bus));
    if (v.e_stall != 0) begin
      chk({tag, ".mem_addr"}, o_addr, v.addr & 32'hFFFF_FFFC);
      chk({tag, ".mem_we"}, 32'(o_we), 32'(v.we));
      chk({tag, ".byteen"}, 32'(o_be), 32'(v.e_be));
      chk({tag, ".ld_valid_done"}, 32'(o_ldv_done), 32'(v.e_ldv));
      if (v.we) chk({tag, ".mem_wdata"}, o_wd, v.e_wd);
      if (v.chk_ld) chk({tag, ".ld_data"}, o_ld, v.e_ld);
    end
  endtask

  vec_t tbl[16];
  vec_t rv;

  initial begin
    tbl[0]  = mkv(1,0,2'b10,0,32'h1003,0,32'h80112233,1,0, 4'b1000,0,32'hFFFFFF80,1,0,0,0,1,2,1);
    tbl[1]  = mkv(1,0,2'b01,1,32'h2002,0,32'hBEEF1234,3,0, 4'b1100,0,32'h0000BEEF,1,0,0,0,3,4,1);
    tbl[2]  = mkv(0,1,2'b10,0,32'h11,32'hA5,0,2,0, 4'b0010,32'hA5A5A5A5,0,0,0,0,0,2,3,0);
    tbl[3]  = mkv(1,0,2'b00,0,32'h6,0,0,1,0, 4'b0000,0,0,0,0,1,0,0,0,0);
    tbl[4]  = mkv(0,1,2'b01,0,32'h5,32'h1234,0,1,0, 4'b0000,0,0,0,0,0,1,0,0,0);
    tbl[5]  = mkv(1,0,2'b00,0,32'h100,0,32'hDEADBEEF,0,0, 4'b1111,0,0,0,1,0,0,4,5,1);
    tbl[6]  = mkv(1,0,2'b00,0,32'h200,0,32'h11111111,3,1, 4'b1111,0,0,0,0,0,0,3,4,0);
    tbl[7]  = mkv(1,0,2'b01,0,32'h2,0,32'h80017FFF,1,0, 4'b1100,0,32'hFFFF8001,1,0,0,0,1,2,1);
    tbl[8]  = mkv(0,1,2'b00,0,32'h40,32'h12345678,0,4,0, 4'b1111,32'h12345678,0,0,0,0,0,4,5,0);
    tbl[9]  = mkv(1,0,2'b00,0,32'h44,0,32'hCAFEF00D,4,0, 4'b1111,0,32'hCAFEF00D,1,0,0,0,4,5,1);
    tbl[10] = mkv(1,0,2'b10,1,32'h2,0,32'h00FF0000,2,0, 4'b0100,0,32'h000000FF,1,0,0,0,2,3,1);
    tbl[11] = mkv(1,0,2'b11,1,32'h8,0,32'h87654321,1,0, 4'b1111,0,32'h87654321,1,0,0,0,1,2,1);
    tbl[12] = mkv(0,1,2'b01,0,32'h2,32'hFFFFBEEF,0,1,0, 4'b1100,32'hBEEFBEEF,0,0,0,0,0,1,2,0);
    tbl[13] = mkv(1,0,2'b00,0,32'h300,0,0,0,2, 4'b1111,0,0,0,0,0,0,4,5,0);
    tbl[14] = mkv(1,0,2'b01,0,32'h0,0,32'h12347FFF,1,0, 4'b0011,0,32'h00007FFF,1,0,0,0,1,2,1);
    tbl[15] = mkv(0,1,2'b10,0,32'h3,32'h5C,0,2,1, 4'b1000,32'h5C5C5C5C,0,0,0,0,0,2,3,0);

    idle_inputs();
    reset = 1'b0;
    #12;
    chk("reset.mem_req", 32'(mem_req), 32'd0);
    chk("reset.mem_we", 32'(mem_we), 32'd0);
    chk("reset.mem_addr", mem_addr, 32'd0);
    chk("reset.mem_byteen", 32'(mem_byteen), 32'd0);
    chk("reset.mem_wdata", mem_wdata, 32'd0);
    chk("reset.ld_data", ld_data, 32'd0);
    chk("reset.ld_valid", 32'(ld_valid), 32'd0);
    chk("reset.exc_bus", 32'(exc_bus), 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      run_txn(tbl[i], $sformatf("tbl%0d", i));
      check_vec(tbl[i], $sformatf("tbl%0d", i));
    end

    // Flush in IDLE suppresses both issue and the misalignment exception.
    m_valid = 1'b1; m_re = 1'b1; m_size = 2'b00; m_addr = 32'h6; flush = 1'b1;
    @(negedge clk);
    chk("idle_flush.exc_adel", 32'(exc_adel), 32'd0);
    chk("idle_flush.stall", 32'(stall), 32'd0);
    m_addr = 32'h8;
    @(negedge clk);
    chk("idle_flush.stall_aligned", 32'(stall), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("idle_flush.mem_req", 32'(mem_req), 32'd0);

    // mem_ready outside WAIT must be ignored.
    @(posedge clk); #1;
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle_ready%0d.ld_valid", i), 32'(ld_valid), 32'd0);
      chk($sformatf("idle_ready%0d.stall", i), 32'(stall), 32'd0);
    end
    @(posedge clk); #1;
    idle_inputs();

    // Reset asserted mid-WAIT drops the request at once with no completion.
    m_valid = 1'b1; m_re = 1'b1; m_size = 2'b00; m_addr = 32'h20;
    @(posedge clk); #1;
    m_valid = 1'b0; m_re = 1'b0;
    @(negedge clk);
    chk("rst_wait.mem_req_before", 32'(mem_req), 32'd1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("rst_wait.mem_req", 32'(mem_req), 32'd0);
    chk("rst_wait.stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_wait%0d.ld_valid", i), 32'(ld_valid), 32'd0);
      chk($sformatf("rst_wait%0d.exc_bus", i), 32'(exc_bus), 32'd0);
      chk($sformatf("rst_wait%0d.mem_req", i), 32'(mem_req), 32'd0);
    end
    @(posedge clk); #1;
    idle_inputs();

    for (int i = 0; i < 200; i++) begin
      rv.re    = $urandom_range(0, 1) == 1;
      rv.we    = !rv.re;
      rv.size  = 2'($urandom_range(0, 3));
      rv.uns   = $urandom_range(0, 1) == 1;
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.k     = $urandom_range(0, 6);
      rv.fl    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      rv = model(rv);
      run_txn(rv, $sformatf("rnd%0d", i));
      check_vec(rv, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
